// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/HALT fetch control with trap, redirect
// and sequential advance, plus one-cycle misaligned-redirect flag.
module pc_sequencer #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
  parameter int unsigned     ALIGN_C      = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic            halt_req,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] current_PC,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned,
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misaligned_q, misaligned_d;
  logic            target_misaligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  always_comb begin
    target_misaligned = 1'b0;
    if (ALIGN_C == 0) target_misaligned = |redirect_target[1:0];
    else              target_misaligned = redirect_target[0];
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    misaligned_d = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        state_d = halt_req ? HALT : RUN;
        // PC update applies even on the edge that enters HALT
        if (trap_valid) begin
          pc_d = TRAP_VECTOR;
        end else if (redirect_valid) begin
          if (target_misaligned) begin
            pc_d         = TRAP_VECTOR;
            misaligned_d = 1'b1;
          end else begin
            pc_d = redirect_target;
          end
        end else if (fetch_ready) begin
          pc_d = pc_q + XLEN'(4);
        end
      end
      HALT:    state_d = halt_req ? HALT : RUN;
      default: state_d = BOOT;
    endcase
  end

  assign fetch_valid = (state_q == RUN);
  assign current_PC  = pc_q;
  assign pc_plus4    = pc_q + XLEN'(4);
  assign misaligned  = misaligned_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: u0 uses 4-byte alignment, u1 2-byte;
// both share stimulus so alignment differences show side by side.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        trap_valid = 1'b0;
  logic        halt_req = 1'b0;
  logic        fetch_ready = 1'b1;

  logic        u0_fv, u1_fv, u0_mis, u1_mis;
  logic [31:0] u0_pc, u1_pc, u0_p4, u1_p4;
  logic [1:0]  u0_st, u1_st;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .ALIGN_C(0)) u0 (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .halt_req(halt_req), .fetch_ready(fetch_ready),
    .fetch_valid(u0_fv), .current_PC(u0_pc), .pc_plus4(u0_p4), .misaligned(u0_mis), .state(u0_st)
  );

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .ALIGN_C(1)) u1 (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .halt_req(halt_req), .fetch_ready(fetch_ready),
    .fetch_valid(u1_fv), .current_PC(u1_pc), .pc_plus4(u1_p4), .misaligned(u1_mis), .state(u1_st)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_pc",    64'(u0_pc),  64'h0);
    check("rst_state", 64'(u0_st),  64'h0);
    check("rst_fv",    64'(u0_fv),  64'h0);
    check("rst_mis",   64'(u0_mis), 64'h0);
    step(); step();
    rst = 1'b0;
    check("boot_state", 64'(u0_st), 64'h0);
    check("boot_fv",    64'(u0_fv), 64'h0);
    step();
    check("run_state", 64'(u0_st), 64'h1);
    check("run_fv",    64'(u0_fv), 64'h1);
    check("pc0",       64'(u0_pc), 64'h0);
    step(); check("pc4", 64'(u0_pc), 64'h4);
    step(); check("pc8", 64'(u0_pc), 64'h8);
    check("pc8_plus4", 64'(u0_p4), 64'hC);
    step(); step(); check("pc10", 64'(u0_pc), 64'h10);

    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); check("stall_hold", 64'(u0_pc), 64'h10);
    end
    fetch_ready = 1'b1;
    step(); check("stall_release", 64'(u0_pc), 64'h14);

    redirect_valid = 1'b1; redirect_target = 32'h200; trap_valid = 1'b1;
    step();
    check("trap_pri_pc",  64'(u0_pc),  64'h100);
    check("trap_pri_mis", 64'(u0_mis), 64'h0);
    trap_valid = 1'b0; redirect_target = 32'h202;
    step();
    check("mis4_pc",  64'(u0_pc),  64'h100);
    check("mis4_flag", 64'(u0_mis), 64'h1);
    check("mis2_pc",  64'(u1_pc),  64'h202);
    check("mis2_flag", 64'(u1_mis), 64'h0);
    redirect_valid = 1'b0;
    step();
    check("mis4_clear", 64'(u0_mis), 64'h0);
    check("mis4_next",  64'(u0_pc),  64'h104);
    check("mis2_next",  64'(u1_pc),  64'h206);
    redirect_valid = 1'b1; redirect_target = 32'h203;
    step();
    check("odd_pc_u1",   64'(u1_pc),  64'h100);
    check("odd_flag_u1", 64'(u1_mis), 64'h1);
    redirect_target = 32'h40; fetch_ready = 1'b0;
    step();
    check("redir_nordy", 64'(u0_pc),  64'h40);
    check("odd_clear_u1", 64'(u1_mis), 64'h0);

    redirect_valid = 1'b0; fetch_ready = 1'b1; halt_req = 1'b1;
    step();
    check("halt_pc",    64'(u0_pc), 64'h44);
    check("halt_state", 64'(u0_st), 64'h2);
    check("halt_fv",    64'(u0_fv), 64'h0);
    redirect_valid = 1'b1; redirect_target = 32'h300; trap_valid = 1'b1;
    step();
    check("halt_ignore_pc", 64'(u0_pc), 64'h44);
    check("halt_hold",      64'(u0_st), 64'h2);
    redirect_valid = 1'b0; trap_valid = 1'b0; halt_req = 1'b0;
    step();
    check("resume_state", 64'(u0_st), 64'h1);
    check("resume_pc",    64'(u0_pc), 64'h44);
    step(); check("resume_adv", 64'(u0_pc), 64'h48);

    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step();
    check("top_pc",    64'(u0_pc), 64'hFFFF_FFFC);
    check("top_plus4", 64'(u0_p4), 64'h0);
    redirect_valid = 1'b0;
    step();
    check("wrap_pc",    64'(u0_pc),  64'h0);
    check("wrap_plus4", 64'(u0_p4),  64'h4);
    check("wrap_mis",   64'(u0_mis), 64'h0);

    redirect_valid = 1'b1; redirect_target = 32'h500;
    step(); // PC now 0x500
    trap_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("midrst_pc",    64'(u0_pc), 64'h0);
    check("midrst_state", 64'(u0_st), 64'h0);
    check("midrst_fv",    64'(u0_fv), 64'h0);
    step();
    rst = 1'b0; redirect_valid = 1'b0; trap_valid = 1'b0;
    check("rerel_boot", 64'(u0_st), 64'h0);
    step();
    check("rerel_pc", 64'(u0_pc), 64'h0);
    check("rerel_fv", 64'(u0_fv), 64'h1);
    step(); check("rerel_adv", 64'(u0_pc), 64'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of every address port; legal values 16..64.
REQ-002 SHALL have parameter RESET_VECTOR, default 0: PC value loaded by reset.
REQ-003 SHALL have parameter TRAP_VECTOR, default 'h100: PC value loaded on trap or misaligned redirect.
REQ-004 SHALL have parameter ALIGN_C, default 0: 0 = targets must be 4-byte aligned; 1 = 2-byte aligned.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-008 SHALL have port redirect_target  input  XLEN  redirect destination.
REQ-009 SHALL have port trap_valid  input  1  exception/interrupt request.
REQ-010 SHALL have port halt_req  input  1  level request to freeze fetch.
REQ-011 SHALL have port fetch_ready  input  1  instruction memory accepts current_PC.
REQ-012 SHALL have port fetch_valid  output  1  current_PC is a valid fetch request.
REQ-013 SHALL have port current_PC  output  XLEN  registered program counter.
REQ-014 SHALL have port pc_plus4  output  XLEN  current_PC + 4, combinational.
REQ-015 SHALL have port misaligned  output  1  registered one-cycle misaligned-target flag.
REQ-016 SHALL have port state  output  2  FSM state for debug: BOOT=00, RUN=01, HALT=10.

Function
REQ-017 SHALL implement FSM BOOT -> RUN unconditionally one cycle after reset release; encoding 11 unreachable, recovers to BOOT.
REQ-018 SHALL transition RUN -> HALT on any rising edge with halt_req=1; HALT -> RUN on first edge with halt_req=0.
REQ-019 SHALL drive fetch_valid=1 only in RUN; 0 in BOOT and HALT.
REQ-020 SHALL update current_PC in RUN with priority: trap_valid > redirect_valid > handshake (fetch_valid & fetch_ready) > hold.
REQ-021 trap_valid SHALL load TRAP_VECTOR on the next edge, regardless of fetch_ready.
REQ-022 Aligned redirect SHALL load redirect_target on the next edge, regardless of fetch_ready.
REQ-023 Misaligned redirect (target[1:0]!=0 when ALIGN_C=0; target[0]!=0 when ALIGN_C=1) SHALL load TRAP_VECTOR and set misaligned=1 for exactly the following cycle.
REQ-024 Handshake without trap/redirect SHALL load current_PC+4; without handshake current_PC SHALL hold.
REQ-025 Addition SHALL be modulo 2^XLEN: all-ones-minus-3 advances to 0 with no flag; pc_plus4 wraps identically.
REQ-026 In BOOT and HALT, trap_valid and redirect_valid SHALL be ignored and current_PC SHALL hold.
REQ-027 halt_req with a same-cycle RUN update SHALL apply the PC update per REQ-020 and enter HALT.
REQ-028 misaligned SHALL be 0 in every cycle not covered by REQ-023.

Reset
REQ-029 rst=1 SHALL immediately, without clock, set current_PC=RESET_VECTOR, state=BOOT, misaligned=0, fetch_valid=0.
REQ-030 Reset asserted mid-operation SHALL abandon any pending redirect/trap; first fetch after release is RESET_VECTOR.
REQ-031 All other outputs SHALL derive from registered state; no output SHALL be X after reset.

Verification
REQ-032 Reset release, fetch_ready=1 constant -> cycle 1 BOOT, fetch_valid=0; then PCs 0x0, 0x4, 0x8 on successive cycles.
REQ-033 fetch_ready=0 for 3 cycles at PC 0x10 -> current_PC holds 0x10; advances to 0x14 one edge after fetch_ready=1.
REQ-034 redirect 0x200 and trap same cycle -> PC=0x100, misaligned=0; redirect 0x202 (ALIGN_C=0) -> PC=0x100, misaligned=1 one cycle; with ALIGN_C=1 -> PC=0x202.
REQ-035 halt_req pulsed 2 cycles at PC 0x40 with handshake -> PC 0x44, state HALT, fetch_valid=0, redirect ignored; resumes RUN from 0x44.
REQ-036 PC=0xFFFF_FFFC, handshake -> PC=0x0, pc_plus4=0x4; rst asserted between edges -> PC=RESET_VECTOR before next clock.
